// File: rtl/mat_stream_engine.sv
// Streaming matrix engine: reads a stored m x n matrix element by element,
// then emits it as a copy, a transpose or a saturated scalar multiple over a
// valid/ready stream.
module mat_stream_engine #(
  parameter int unsigned DIM_WIDTH  = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SLOT_WIDTH = 2,
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [DIM_WIDTH-1:0]   m_sel,
  input  logic [DIM_WIDTH-1:0]   n_sel,
  input  logic [SLOT_WIDTH-1:0]  slot_sel,
  input  logic                   slot_valid,
  input  logic [DATA_WIDTH-1:0]  scalar,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             err_code,
  output logic [2*DIM_WIDTH-1:0] total_elements,
  output logic                   rd_en,
  output logic [SLOT_WIDTH-1:0]  rd_slot_idx,
  output logic [DIM_WIDTH-1:0]   rd_row_idx,
  output logic [DIM_WIDTH-1:0]   rd_col_idx,
  input  logic [DATA_WIDTH-1:0]  rd_elem,
  input  logic                   rd_elem_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_elem,
  output logic                   out_row_end,
  output logic                   out_last,
  output logic [DIM_WIDTH-1:0]   out_row_idx,
  output logic [DIM_WIDTH-1:0]   out_col_idx,
  output logic [2*DIM_WIDTH-1:0] out_linear_idx
);

  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned TW  = 2 * DIM_WIDTH;
  localparam int unsigned WCW = $clog2(RD_TIMEOUT + 1);

  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [1:0] MODE_COPY  = 2'b00;
  localparam logic [1:0] MODE_TRANS = 2'b01;
  localparam logic [1:0] MODE_SCALE = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, CHECK, REQ, WAIT, HOLD, DONE, ERROR
  } state_t;

  state_t                 state;
  logic [1:0]             mode_q;
  logic [DIM_WIDTH-1:0]   m_q, n_q;
  logic                   slot_valid_q;
  logic [DATA_WIDTH-1:0]  scalar_q;
  logic [DIM_WIDTH-1:0]   r, c;
  logic [WCW-1:0]         wait_cnt;

  logic                   transpose;
  logic [DIM_WIDTH-1:0]   rows, cols;
  logic                   last_col, last_row;
  logic [DIM_WIDTH-1:0]   r_nxt, c_nxt;
  logic signed [PW-1:0]   prod;
  logic [DATA_WIDTH-1:0]  proc_elem;

  // Output geometry, next position and processed (possibly saturated) element
  always_comb begin
    transpose = (mode_q == MODE_TRANS);
    rows      = transpose ? n_q : m_q;
    cols      = transpose ? m_q : n_q;
    last_col  = (c == cols - DIM_WIDTH'(1));
    last_row  = (r == rows - DIM_WIDTH'(1));
    c_nxt     = last_col ? '0 : c + DIM_WIDTH'(1);
    r_nxt     = last_col ? r + DIM_WIDTH'(1) : r;
    prod      = PW'($signed(rd_elem)) * PW'($signed(scalar_q));
    proc_elem = rd_elem;
    if (mode_q == MODE_SCALE) begin
      if (prod > SAT_MAX)      proc_elem = SAT_MAX[DATA_WIDTH-1:0];
      else if (prod < SAT_MIN) proc_elem = SAT_MIN[DATA_WIDTH-1:0];
      else                     proc_elem = prod[DATA_WIDTH-1:0];
    end
  end

  // Control FSM with all status, read-port and stream outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mode_q         <= MODE_COPY;
      m_q            <= '0;
      n_q            <= '0;
      slot_valid_q   <= 1'b0;
      scalar_q       <= '0;
      r              <= '0;
      c              <= '0;
      wait_cnt       <= '0;
      ready          <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 3'b000;
      total_elements <= '0;
      rd_en          <= 1'b0;
      rd_slot_idx    <= '0;
      rd_row_idx     <= '0;
      rd_col_idx     <= '0;
      out_valid      <= 1'b0;
      out_elem       <= '0;
      out_row_end    <= 1'b0;
      out_last       <= 1'b0;
      out_row_idx    <= '0;
      out_col_idx    <= '0;
      out_linear_idx <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      rd_en <= 1'b0;
      if (abort && (state inside {CHECK, REQ, WAIT, HOLD})) begin
        // abort wins over everything, including a same-cycle handshake
        state     <= ERROR;
        err_code  <= 3'b101;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        error     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_q         <= mode;
              m_q            <= m_sel;
              n_q            <= n_sel;
              slot_valid_q   <= slot_valid;
              scalar_q       <= scalar;
              rd_slot_idx    <= slot_sel;
              total_elements <= TW'(m_sel) * TW'(n_sel);
              err_code       <= 3'b000;
              r              <= '0;
              c              <= '0;
              wait_cnt       <= '0;
              ready          <= 1'b0;
              busy           <= 1'b1;
              state          <= CHECK;
            end
          end
          CHECK: begin
            if (mode_q == MODE_RSVD) begin
              err_code <= 3'b011;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= ERROR;
            end else if (!slot_valid_q) begin
              err_code <= 3'b001;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= ERROR;
            end else if (m_q == '0 || n_q == '0) begin
              err_code <= 3'b010;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= ERROR;
            end else begin
              rd_row_idx <= '0;
              rd_col_idx <= '0;
              rd_en      <= 1'b1;
              state      <= REQ;
            end
          end
          REQ: begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            if (rd_elem_valid) begin
              out_elem       <= proc_elem;
              out_valid      <= 1'b1;
              out_row_idx    <= r;
              out_col_idx    <= c;
              out_linear_idx <= TW'(r) * TW'(cols) + TW'(c);
              out_row_end    <= last_col;
              out_last       <= last_col && last_row;
              state          <= HOLD;
            end else if (wait_cnt == WCW'(RD_TIMEOUT - 1)) begin
              err_code <= 3'b100;
              error    <= 1'b1;
              busy     <= 1'b0;
              state    <= ERROR;
            end else begin
              wait_cnt <= wait_cnt + WCW'(1);
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              r         <= r_nxt;
              c         <= c_nxt;
              if (last_col && last_row) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else begin
                rd_row_idx <= transpose ? c_nxt : r_nxt;
                rd_col_idx <= transpose ? r_nxt : c_nxt;
                rd_en      <= 1'b1;
                state      <= REQ;
              end
            end
          end
          DONE: begin
            ready <= 1'b1;
            state <= IDLE;
          end
          ERROR: begin
            ready <= 1'b1;
            state <= IDLE;
          end
          default: begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mat_stream_engine.md
MAT_STREAM_ENGINE -- requirements
Module: mat_stream_engine

Interface
REQ-001 Parameter DIM_WIDTH, default 3, SHALL set the width of the row, column and dimension fields.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the element width (signed two's complement).
REQ-003 Parameter SLOT_WIDTH, default 2, SHALL set the slot index width (2^SLOT_WIDTH storage slots).
REQ-004 Parameter RD_TIMEOUT, default 15, SHALL set the maximum number of cycles waited for rd_elem_valid.
REQ-005 The ports SHALL be as follows (clock and reset first):
 clk  in  1  clock, rising edge
 rst_n  in  1  asynchronous, active-low reset
 start  in  1  begin operation, accepted only while ready=1
 abort  in  1  cancel operation in progress
 mode  in  2  00 copy, 01 transpose, 10 scale, 11 reserved
 m_sel, n_sel  in  DIM_WIDTH  source rows, source columns
 slot_sel  in  SLOT_WIDTH  source slot; slot_valid  in  1  slot holds data
 scalar  in  DATA_WIDTH  signed multiplier, used in scale mode
 ready, busy, done, error  out  1  status (done and error are 1-cycle pulses)
 err_code  out  3  latched error cause
 total_elements  out  2*DIM_WIDTH  m*n
 rd_en  out  1; rd_slot_idx  out  SLOT_WIDTH; rd_row_idx, rd_col_idx  out  DIM_WIDTH
 rd_elem  in  DATA_WIDTH; rd_elem_valid  in  1
 out_valid  out  1; out_ready  in  1
 out_elem  out  DATA_WIDTH; out_row_end, out_last  out  1
 out_row_idx, out_col_idx  out  DIM_WIDTH; out_linear_idx  out  2*DIM_WIDTH

Function
REQ-006 The FSM SHALL have the states IDLE, CHECK, REQ, WAIT, HOLD, DONE and ERROR.
REQ-007 IDLE: ready=1 and busy=0; when start=1, the block SHALL latch mode, m, n, slot, slot_valid and scalar, set total_elements=m*n, clear the counters, and go to CHECK with ready=0 and busy=1.
REQ-008 CHECK SHALL evaluate errors in this priority, then go to ERROR on any error or to REQ otherwise:
 - mode=11 -> err_code 011
 - !slot_valid -> err_code 001
 - m=0 or n=0 -> err_code 010
REQ-009 Output dimensions SHALL be rows=m, cols=n in copy and scale mode, and rows=n, cols=m in transpose mode.
REQ-010 Read address (r = output row counter, c = output column counter):
 - copy and scale: rd_row_idx=r, rd_col_idx=c
 - transpose: rd_row_idx=c, rd_col_idx=r
 - rd_slot_idx = latched slot
REQ-011 REQ SHALL assert rd_en for exactly one cycle with a stable address, then go to WAIT.
REQ-012 WAIT SHALL keep rd_en=0 and hold the address until rd_elem_valid; it SHALL then capture the processed element into out_elem, set out_valid=1, and go to HOLD.
REQ-013 A rd_elem_valid pulse outside WAIT SHALL be ignored.
REQ-014 WAIT SHALL count cycles; reaching RD_TIMEOUT cycles without rd_elem_valid SHALL go to ERROR with err_code 100.
REQ-015 Scale mode SHALL form the full 2*DATA_WIDTH signed product rd_elem*scalar and saturate it to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; copy and transpose SHALL pass rd_elem unchanged.
REQ-016 While out_valid=1, out_elem, out_row_idx=r, out_col_idx=c, out_linear_idx=r*cols+c, out_row_end=(c==cols-1) and out_last=(last element) SHALL be driven and held stable.
REQ-017 HOLD SHALL keep out_valid=1 until out_ready=1.
REQ-018 On the handshake cycle, out_valid SHALL drop next cycle; c SHALL increment, or wrap to 0 with r incrementing; the FSM SHALL go to DONE if it was the last element, or to REQ otherwise.
REQ-019 Handshake throughput SHALL be at most one element per 3 cycles; zero-latency rd_elem_valid in the cycle after REQ SHALL be supported.
REQ-020 DONE SHALL pulse done=1 for 1 cycle with busy=0, then go to IDLE.
REQ-021 ERROR SHALL pulse error=1 for 1 cycle with busy=0, then go to IDLE.
REQ-022 err_code SHALL hold its value until the next accepted start, which SHALL clear it to 000.
REQ-023 abort=1 in any state other than IDLE, DONE or ERROR SHALL move the FSM to ERROR on the next edge with err_code 101, and out_valid SHALL be cleared in that same edge.
REQ-024 abort SHALL take priority over a simultaneous handshake; abort in IDLE SHALL be ignored.
REQ-025 start while busy=1 SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE with ready=1 and every other output at 0 (err_code 000, indices 0, out_elem 0); the first rising edge after release SHALL be able to accept start.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done or error pulse.

Verification
REQ-028 Transpose 2x3, src [[1,2,3],[4,5,6]], out_ready=1 -> stream 1,4,2,5,3,6; row_end after 4, 5 and 6; out_last on 6; linear 0..5; done pulse.
REQ-029 Scale 1x3, scalar=-2, src [100,-70,3] -> out -128,127,-6 (saturated, saturated, exact).
REQ-030 Copy 2x2 with out_ready low for 4 cycles on element 2 -> out_elem and indices held stable, no extra rd_en, order 1,2,3,4.
REQ-031 start with slot_valid=0 and m=0 -> error pulse, err_code 001; mode=11 -> err_code 011.
REQ-032 rd_elem_valid withheld for 15 cycles -> error, err_code 100; abort during HOLD -> out_valid cleared next cycle, err_code 101, no done.
REQ-033 rst_n pulsed low during WAIT -> all outputs return to reset values immediately; a new start is accepted after release.
